// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: chunked carry-pipelined adder/subtractor with valid/ready flow control and flags
// Ports: i_clock, i_reset (async, active-high); i_in_valid/o_in_ready with i_data_a, i_data_b,
// i_carry_in, i_sub form the input handshake; o_out_valid/i_out_ready with o_result, o_carry_out,
// o_overflow, o_zero form the output handshake.
module pipelined_add_sub #(
  parameter int NrOfBits   = 8,
  parameter int NrOfStages = 2
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [NrOfBits-1:0] i_data_a,
  input  logic [NrOfBits-1:0] i_data_b,
  input  logic                i_carry_in,
  input  logic                i_sub,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [NrOfBits-1:0] o_result,
  output logic                o_carry_out,
  output logic                o_overflow,
  output logic                o_zero
);
  localparam int W = NrOfBits;
  localparam int S = NrOfStages;
  localparam int C = W / S;
  logic [S-1:0] r_v, r_c, r_s, w_ld, w_vi, w_ci, w_si;
  logic [W-1:0] r_a [S];
  logic [W-1:0] r_b [S];
  logic [W-1:0] r_r [S];
  logic [W-1:0] w_ai [S];
  logic [W-1:0] w_bi [S];
  logic [W-1:0] w_ri [S];
  logic [C:0]   w_sum [S];
  logic         w_go;
  // a stage loads when empty or when the stage after it loads; the last stage looks at the consumer
  always_comb begin
    w_ld = '0;
    w_go = i_out_ready;
    for (int k = S - 1; k >= 0; k--) begin
      w_go    = ~r_v[k] | w_go;
      w_ld[k] = w_go;
    end
  end
  assign o_in_ready = w_ld[0];
  // B is stored already inverted for subtraction so every stage is a plain adder
  for (genvar k = 0; k < S; k++) begin : g_st
    if (k == 0) begin : g_first
      assign w_vi[0] = i_in_valid;
      assign w_ai[0] = i_data_a;
      assign w_bi[0] = i_sub ? ~i_data_b : i_data_b;
      assign w_ri[0] = '0;
      assign w_ci[0] = i_carry_in ^ i_sub;
      assign w_si[0] = i_sub;
    end else begin : g_next
      assign w_vi[k] = r_v[k-1];
      assign w_ai[k] = r_a[k-1];
      assign w_bi[k] = r_b[k-1];
      assign w_ri[k] = r_r[k-1];
      assign w_ci[k] = r_c[k-1];
      assign w_si[k] = r_s[k-1];
    end
    assign w_sum[k] = {1'b0, w_ai[k][k*C +: C]} + {1'b0, w_bi[k][k*C +: C]} + {{C{1'b0}}, w_ci[k]};
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_v <= '0;
      r_c <= '0;
      r_s <= '0;
      for (int k = 0; k < S; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (w_ld[k]) begin
          r_v[k]             <= w_vi[k];
          r_s[k]             <= w_si[k];
          r_c[k]             <= w_sum[k][C];
          r_a[k]             <= w_ai[k];
          r_b[k]             <= w_bi[k];
          r_r[k]             <= w_ri[k];
          r_r[k][k*C +: C]   <= w_sum[k][C-1:0];
        end
      end
    end
  end
  assign o_out_valid = r_v[S-1];
  assign o_result    = r_r[S-1];
  assign o_carry_out = r_c[S-1] ^ r_s[S-1];
  assign o_overflow  = (r_a[S-1][W-1] == r_b[S-1][W-1]) & (r_r[S-1][W-1] != r_a[S-1][W-1]);
  assign o_zero      = r_v[S-1] & ~|r_r[S-1];
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed and randomized checks of pipelined_add_sub for 1, 2, 4 and 8 stages
module tb_pipelined_add_sub;
  logic clk = 0, rst = 0, ivld = 0, ordy = 0, cin = 0, sub = 0, mon = 0, fin = 0;
  logic [7:0] a = 0, b = 0;
  logic [3:0] rdy, vld, co, ovf, zr;
  logic [7:0] res [4];
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // {zero, overflow, carry/borrow, result} from plain integer arithmetic
  function automatic logic [10:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s);
    int u, v;
    logic [7:0] r;
    logic cy;
    if (s) begin
      u = int'(x) - int'(y) - int'(ci);
      v = int'($signed(x)) - int'($signed(y)) - int'(ci);
      cy = u < 0;
    end else begin
      u = int'(x) + int'(y) + int'(ci);
      v = int'($signed(x)) + int'($signed(y)) + int'(ci);
      cy = u > 255;
    end
    r = u[7:0];
    return {r == 8'h00, (v > 127) || (v < -128), cy, r};
  endfunction
  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [10:0] q [$];
    logic [10:0] e;
    pipelined_add_sub #(.NrOfBits(8), .NrOfStages(1 << g)) u_dut (
      .i_clock(clk), .i_reset(rst), .i_in_valid(ivld), .o_in_ready(rdy[g]),
      .i_data_a(a), .i_data_b(b), .i_carry_in(cin), .i_sub(sub),
      .o_out_valid(vld[g]), .i_out_ready(ordy), .o_result(res[g]),
      .o_carry_out(co[g]), .o_overflow(ovf[g]), .o_zero(zr[g]));
    always @(negedge clk) if (mon) begin
      if (vld[g] && ordy) begin
        chk($sformatf("rand_s%0d_pending", 1 << g), 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk($sformatf("rand_s%0d_value", 1 << g), 64'({zr[g], ovf[g], co[g], res[g]}), 64'(e));
        end
      end
      if (ivld && rdy[g]) q.push_back(ref_op(a, b, cin, sub));
    end
    always @(posedge fin) chk($sformatf("rand_s%0d_left", 1 << g), 64'(q.size()), 64'(0));
  end
  task automatic run1(input string tag, input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s, input logic [10:0] exp);
    a = x; b = y; cin = ci; sub = s; ivld = 1;
    @(negedge clk) chk({tag, "_rdy"}, 64'(rdy[1]), 64'(1));
    @(posedge clk) #1 ivld = 0;
    @(negedge clk) chk({tag, "_early"}, 64'(vld[1]), 64'(0));
    @(posedge clk);
    @(negedge clk) begin
      chk({tag, "_vld"}, 64'(vld[1]), 64'(1));
      chk({tag, "_val"}, 64'({zr[1], ovf[1], co[1], res[1]}), 64'(exp));
    end
    @(posedge clk) #1;
  endtask
  logic [7:0] da [4] = '{8'h01, 8'h22, 8'hF0, 8'h7F};
  logic [7:0] db [4] = '{8'h02, 8'h33, 8'h10, 8'h80};
  logic       dc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       ds [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    int k;
    #1 rst = 1;
    @(negedge clk) begin
      chk("rst_vld", 64'(vld), 64'(0));
      chk("rst_rdy", 64'(rdy), 64'hF);
      chk("rst_out", 64'({zr[1], ovf[1], co[1], res[1]}), 64'(0));
    end
    @(posedge clk) #1 rst = 0;
    ordy = 1;
    run1("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 11'h280);
    run1("add_carry", 8'hFF, 8'h00, 1'b1, 1'b0, 11'h500);
    run1("sub_borrow", 8'h10, 8'h20, 1'b1, 1'b1, 11'h1EF);
    run1("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 11'h27F);
    ordy = 0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      a = da[k]; b = db[k]; cin = dc[k]; sub = ds[k]; ivld = 1;
      @(negedge clk);
      chk("bp_rdy", 64'(rdy[1]), 64'(c < 2));
      if (c >= 2) begin
        chk("bp_vld", 64'(vld[1]), 64'(1));
        chk("bp_hold", 64'({zr[1], ovf[1], co[1], res[1]}), 64'(ref_op(da[0], db[0], dc[0], ds[0])));
      end
      if (rdy[1]) k++;
      @(posedge clk) #1;
    end
    ordy = 1;
    for (int j = 0; j < 4; j++) begin
      if (k < 4) begin a = da[k]; b = db[k]; cin = dc[k]; sub = ds[k]; end
      ivld = k < 4;
      @(negedge clk);
      chk("bp_vld2", 64'(vld[1]), 64'(1));
      chk("bp_order", 64'({zr[1], ovf[1], co[1], res[1]}), 64'(ref_op(da[j], db[j], dc[j], ds[j])));
      if (ivld && rdy[1]) k++;
      @(posedge clk) #1;
    end
    ivld = 0;
    chk("bp_count", 64'(k), 64'(4));
    a = 8'h11; b = 8'h22; cin = 0; sub = 0; ivld = 1;
    @(posedge clk) #1 a = 8'h33;
    @(posedge clk) #1 ivld = 0;
    rst = 1;
    #1 begin
      chk("mid_rst_vld", 64'(vld[1]), 64'(0));
      chk("mid_rst_rdy", 64'(rdy[1]), 64'(1));
      chk("mid_rst_out", 64'({zr[1], ovf[1], co[1], res[1]}), 64'(0));
    end
    @(posedge clk) #1 rst = 0;
    run1("after_rst", 8'h05, 8'h03, 1'b1, 1'b1, 11'h001);
    rst = 1;
    @(posedge clk) #1 rst = 0;
    mon = 1;
    for (int c = 0; c < 3000; c++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      ivld = $urandom_range(3) != 0;
      ordy = $urandom_range(2) != 0;
      @(posedge clk) #1;
    end
    ivld = 0;
    ordy = 1;
    repeat (20) @(posedge clk);
    #1 fin = 1;
    #1 mon = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 Parameter NrOfBits, default 8: operand and result width, 2..64.
REQ-002 Parameter NrOfStages, default 2: pipeline stages, 1..NrOfBits; NrOfBits SHALL be an integer multiple of NrOfStages.
REQ-003 Clock  input  1  single clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all pipeline state.
REQ-005 InValid  input  1  operand set present on DataA/DataB/CarryIn/Sub.
REQ-006 InReady  output  1  block accepts the operand set this cycle.
REQ-007 DataA  input  NrOfBits  operand A.
REQ-008 DataB  input  NrOfBits  operand B.
REQ-009 CarryIn  input  1  carry-in (Sub=0) or borrow-in (Sub=1).
REQ-010 Sub  input  1  0 = add, 1 = subtract.
REQ-011 OutValid  output  1  Result and flags hold a completed operation.
REQ-012 OutReady  input  1  consumer takes the result this cycle.
REQ-013 Result  output  NrOfBits  sum or difference, modulo 2^NrOfBits.
REQ-014 CarryOut  output  1  carry-out (Sub=0) or borrow-out (Sub=1).
REQ-015 Overflow  output  1  two's-complement signed overflow.
REQ-016 Zero  output  1  Result equals 0.

Function
REQ-017 Operand set SHALL be accepted on a rising edge exactly when InValid=1 and InReady=1.
REQ-018 Chunk width C = NrOfBits/NrOfStages; stage k (0-based) SHALL add bits [k*C+C-1 : k*C] using the carry registered by stage k-1; stage 0 SHALL use the effective carry-in.
REQ-019 Sub=0: Result = DataA + DataB + CarryIn; CarryOut = carry out of the MSB.
REQ-020 Sub=1: internal = DataA + ~DataB + ~CarryIn; Result = DataA - DataB - CarryIn; CarryOut = inverse of the MSB carry (borrow).
REQ-021 Overflow SHALL be set when the MSBs of DataA and the effective B operand (DataB or ~DataB) are equal and differ from the Result MSB.
REQ-022 Zero SHALL be computed from the full final Result.
REQ-023 Each stage SHALL hold a valid bit; operand chunks not yet consumed and result chunks already produced SHALL travel with their operation.
REQ-024 Latency with no backpressure SHALL be exactly NrOfStages cycles from acceptance to OutValid=1; throughput one operation per cycle.
REQ-025 Stage k SHALL load when it is empty or stage k+1 loads (last stage: when OutValid=0 or OutReady=1); InReady SHALL equal the stage-0 load condition, combinationally from OutReady and the valid bits.
REQ-026 Bubbles SHALL be removed: an empty stage accepts new data even while later stages are stalled.
REQ-027 While OutValid=1 and OutReady=0, Result, CarryOut, Overflow, Zero SHALL remain stable.
REQ-028 Input and output transfer in the same cycle when full SHALL be lossless: no operation dropped or duplicated, order preserved.
REQ-029 No operation SHALL be dropped, duplicated or reordered under any InValid/OutReady pattern.
REQ-030 NrOfStages=1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-031 Reset assertion SHALL immediately clear all valid bits: OutValid=0, Result=0, CarryOut=0, Overflow=0, Zero=0.
REQ-032 InReady SHALL be 1 whenever all valid bits are 0 (including during and after reset).
REQ-033 Reset mid-operation SHALL discard all in-flight operations; the first accepted set after release SHALL complete normally.

Verification (NrOfBits=8, NrOfStages=2 unless stated)
REQ-034 Add, OutReady=1: A=0x7F, B=0x01, CarryIn=0, Sub=0 -> 2 cycles later OutValid=1, Result=0x80, CarryOut=0, Overflow=1, Zero=0.
REQ-035 Inter-chunk carry: A=0xFF, B=0x00, CarryIn=1, Sub=0 -> Result=0x00, CarryOut=1, Overflow=0, Zero=1.
REQ-036 Subtract with borrow: A=0x10, B=0x20, CarryIn=1, Sub=1 -> Result=0xEF, CarryOut=1, Overflow=0; A=0x80, B=0x01, CarryIn=0, Sub=1 -> Result=0x7F, Overflow=1.
REQ-037 Backpressure: stream 4 back-to-back sets with OutReady=0 -> after 2 accepts InReady=0, outputs frozen; raise OutReady -> all 4 results in input order, one per cycle.
REQ-038 Reset mid-flight: accept 2 sets, assert Reset one cycle -> OutValid=0, InReady=1; next set after release emerges after 2 cycles with correct value.
REQ-039 Random stimulus, NrOfStages in {1,2,4,8}, random InValid/OutReady -> every result matches reference model, order preserved, none lost.
